tuner_cic_decim: RTL and testbench
==================================

Name: tuner_cic_decim

Overview:
- Dual-channel (I/Q) CIC decimator directly downstream of the tuner; consumes its out_i/out_q every clock.
- N-stage integrator/comb chain, power-of-two decimation R = 2^decim, unity DC gain by bit slicing.
- Produces decimated complex samples with a single-cycle valid strobe for the following filter and FIFO stages.

Parameters:
- DSZ, 16, input and output sample width (signed)
- NST, 4, number of integrator and comb stages
- LSZ, 4, width of the decim control word
- DMAX, 8, maximum decim value (R max = 256)
- ASZ, DSZ + NST*DMAX (48), internal accumulator width (signed)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_i  in  DSZ  signed in-phase sample from the tuner, valid every clock
- in_q  in  DSZ  signed quadrature sample from the tuner, valid every clock
- decim  in  LSZ  log2 of the decimation rate
- out_i  out  DSZ  signed decimated in-phase output
- out_q  out  DSZ  signed decimated quadrature output
- out_valid  out  1  one-cycle strobe; out_i/out_q are valid when high

Behaviour:
- Reset (asynchronous, reset = 0): all integrators, combs, the counter and output registers clear to 0. out_valid = 0, out_i = 0, out_q = 0. Releasing reset mid-stream restarts cleanly; no partial output is emitted.
- Effective rate: decim is clamped to 1..DMAX. A value of 0 acts as 1; a value greater than DMAX acts as DMAX. The clamped value is registered each clock as d_eff.
- Integrators:
  - NST cascaded, each registered.
  - Stage 0 takes in_i/in_q sign-extended to ASZ.
  - Modular two's-complement arithmetic; wrap-around is intended and must not be saturated.
- Decimation counter:
  - Counts 0..2^d_eff − 1 and wraps.
  - At the wrap, the last integrator output is captured into the comb section (strobe cycle).
- Combs:
  - NST cascaded, differential delay 1. Each stage holds one delay register updated only on a strobe.
  - The whole comb chain is evaluated combinationally on the strobe and registered, so it advances one step per strobe.
- Output:
  - Slice comb result bits [DSZ−1+NST*d_eff : NST*d_eff]. This gives a gain of R^NST / 2^(NST*d_eff) = 1.
  - out_i/out_q and out_valid are registered.
  - out_valid is high exactly one clock, two clocks after the strobe cycle. Outputs hold their value between strobes.
- Latency: input to integrator output is NST clocks; strobe to out_valid is 2 clocks.
- Rate change (d_eff differs from the previous cycle):
  - Counter resets to 0.
  - Comb delay registers clear.
  - The next NST strobes are suppressed (out_valid stays 0) while the pipeline refills.
  - Integrators are not cleared.
- I and Q share the counter, strobe and suppression logic, so they are always sample-aligned.

Optional Feature:
- Macro: TUNER_CIC_ROUND_EN.
- Defined:
  - Output is rounded half-up: add 2^(NST*d_eff − 1) before slicing.
  - The result saturates to [−2^(DSZ−1), 2^(DSZ−1) − 1].
  - Adds one register stage, so strobe to out_valid becomes 3 clocks.
- Undefined: plain truncation (floor), no saturation logic, latency 2 clocks.

Decomposition:
- Package tuner_pkg holds DSZ, NST, LSZ, DMAX and ASZ.
- Package typedefs: acc_t (signed ASZ) and sample_t (signed DSZ).
- Sub-module cic_channel: one channel's integrators, combs and output slice. It takes the strobe, d_eff and flush as inputs and is instantiated once each for I and Q.
- The counter, rate-change detection and suppression logic live in the top level.

Test Plan:
- DC input, in_i = 1000 and in_q = −1000, decim = 3 (R = 8) -> after settling, out_i = 1000 and out_q = −1000; out_valid pulses every 8 clocks.
- Full scale, in_i = 32767 and in_q = −32768, decim = 8 (R = 256) -> out_i = 32767 and out_q = −32768 exactly; integrator wrap causes no error.
- Clamping, decim = 0 -> pulse every 2 clocks; decim = 15 -> pulse every 256 clocks.
- Rate change from decim = 2 to decim = 4 mid-stream -> exactly NST = 4 strobes are suppressed, after which DC output is correct with a 16-clock period.
- reset driven to 0 for 1 clock mid-frame -> outputs and out_valid go to 0 immediately (asynchronously); the first pulse after release arrives 2^d_eff + 2 clocks later.
- TUNER_CIC_ROUND_EN defined, in_i alternating 1 and 2, decim = 1 -> out_i = 2 (rounded), versus 1 with the macro undefined.

Source files
------------

// File: rtl/tuner_pkg.sv
// Shared widths, sample/accumulator types and rate clamp for the tuner CIC decimator.
// Pure declarations: no latency, no flow control.
package tuner_pkg;
    localparam int DSZ  = 16;
    localparam int NST  = 4;
    localparam int LSZ  = 4;
    localparam int DMAX = 8;
    localparam int ASZ  = DSZ + NST * DMAX;
    localparam int SHW  = $clog2(NST * DMAX + 1);
    localparam int SUPW = $clog2(NST + 1);

    typedef logic signed [ASZ-1:0] acc_t;
    typedef logic signed [DSZ-1:0] sample_t;
    typedef logic [DMAX-1:0]       cnt_t;
    typedef logic [SUPW-1:0]       sup_t;
    typedef logic [LSZ-1:0]        dec_t;

    function automatic dec_t clamp_decim(input dec_t d);
        if (d == '0)
            return dec_t'(1);
        if (d > dec_t'(DMAX))
            return dec_t'(DMAX);
        return d;
    endfunction
endpackage

// File: rtl/cic_channel.sv
// One CIC channel: NST integrators, NST strobed combs, unity-gain slice (rounded/saturated when TUNER_CIC_ROUND_EN).
// Latency strobe->res_o 1 clock (2 with rounding); no backpressure, input consumed every clock.
module cic_channel
    import tuner_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t samp_i,
    input  logic    strb_i,
    input  logic    flush_i,
    input  dec_t    d_eff_i,
    output sample_t res_o
);
    logic [SHW-1:0] sh;
    acc_t           integ_q [NST];
    acc_t           dly_q   [NST];
    acc_t           dly_d   [NST];
    acc_t           c_acc;
    acc_t           comb_d;
    acc_t           comb_q;

    assign sh = SHW'(NST) * SHW'(d_eff_i);

    // Whole comb chain settles in one cycle; each delay register keeps its stage input.
    always_comb begin
        c_acc = integ_q[NST-1];
        for (int k = 0; k < NST; k++) begin
            dly_d[k] = c_acc;
            c_acc    = c_acc - dly_q[k];
        end
        comb_d = c_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NST; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            comb_q <= '0;
        end else begin
            integ_q[0] <= integ_q[0] + acc_t'(samp_i);
            for (int k = 1; k < NST; k++)
                integ_q[k] <= integ_q[k] + integ_q[k-1];
            if (flush_i) begin
                for (int k = 0; k < NST; k++)
                    dly_q[k] <= '0;
            end else if (strb_i) begin
                for (int k = 0; k < NST; k++)
                    dly_q[k] <= dly_d[k];
                comb_q <= comb_d;
            end
        end
    end

`ifdef TUNER_CIC_ROUND_EN
    localparam acc_t SMAX = acc_t'(2 ** (DSZ - 1) - 1);
    localparam acc_t SMIN = -acc_t'(2 ** (DSZ - 1));
    acc_t    rnd;
    acc_t    shf;
    sample_t res_q;

    always_comb begin
        rnd = comb_q + (acc_t'(1) <<< (sh - SHW'(1)));
        shf = rnd >>> sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_q <= '0;
        else if (shf > SMAX)
            res_q <= sample_t'(SMAX);
        else if (shf < SMIN)
            res_q <= sample_t'(SMIN);
        else
            res_q <= sample_t'(shf);
    end

    assign res_o = res_q;
`else
    assign res_o = sample_t'(comb_q >>> sh);
`endif
endmodule

// File: rtl/tuner_cic_decim.sv
// I/Q CIC decimator by 2^decim; shared counter, rate-change flush and refill suppression.
// Strobe->out_valid 2 clocks (3 with TUNER_CIC_ROUND_EN); no backpressure, one sample per clock.
module tuner_cic_decim
    import tuner_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [DSZ-1:0] in_i,
    input  logic signed [DSZ-1:0] in_q,
    input  logic [LSZ-1:0]        decim,
    output logic signed [DSZ-1:0] out_i,
    output logic signed [DSZ-1:0] out_q,
    output logic                  out_valid
);
    localparam cnt_t CNT_ONES = '1;

    dec_t    d_clamp;
    dec_t    d_eff_q;
    logic    primed_q;
    cnt_t    cnt_q;
    cnt_t    mask;
    sup_t    sup_q;
    logic    wrap;
    logic    chg;
    logic    strb;
    logic    emit;
    logic    v1_q;
    logic    vld_last;
    sample_t ch_i_res;
    sample_t ch_q_res;
    sample_t oi_q;
    sample_t oq_q;
    logic    out_valid_q;

    assign d_clamp = clamp_decim(decim);
    assign mask    = ~(CNT_ONES << d_eff_q);
    // primed_q keeps the first cycle after reset from counting as a rate change.
    assign wrap    = primed_q && (cnt_q == mask);
    assign chg     = primed_q && (d_clamp != d_eff_q);
    assign strb    = wrap && !chg;
    assign emit    = strb && (sup_q == '0);

`ifdef TUNER_CIC_ROUND_EN
    logic v2_q;
    assign vld_last = v2_q;
`else
    assign vld_last = v1_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_eff_q     <= '0;
            primed_q    <= 1'b0;
            cnt_q       <= '0;
            sup_q       <= '0;
            v1_q        <= 1'b0;
`ifdef TUNER_CIC_ROUND_EN
            v2_q        <= 1'b0;
`endif
            oi_q        <= '0;
            oq_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            d_eff_q  <= d_clamp;
            primed_q <= 1'b1;
            if (!primed_q || chg || wrap)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + cnt_t'(1);
            if (chg)
                sup_q <= sup_t'(NST);
            else if (strb && (sup_q != '0))
                sup_q <= sup_q - sup_t'(1);
            v1_q <= emit;
`ifdef TUNER_CIC_ROUND_EN
            v2_q <= v1_q;
`endif
            out_valid_q <= vld_last;
            if (vld_last) begin
                oi_q <= ch_i_res;
                oq_q <= ch_q_res;
            end
        end
    end

    cic_channel u_chan_i (
        .clk     (clk),
        .rst_n   (reset),
        .samp_i  (in_i),
        .strb_i  (strb),
        .flush_i (chg),
        .d_eff_i (d_eff_q),
        .res_o   (ch_i_res)
    );

    cic_channel u_chan_q (
        .clk     (clk),
        .rst_n   (reset),
        .samp_i  (in_q),
        .strb_i  (strb),
        .flush_i (chg),
        .d_eff_i (d_eff_q),
        .res_o   (ch_q_res)
    );

    assign out_i     = oi_q;
    assign out_q     = oq_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_tuner_cic_decim.sv
// Scoreboard bench: reference is the CIC impulse response (boxcar^NST) applied to the input history.
module tb_tuner_cic_decim;
    import tuner_pkg::*;

`ifdef TUNER_CIC_ROUND_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int MAXC = 20000;

    typedef struct {
        int i;
        int q;
        int cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic signed [DSZ-1:0] in_i;
    logic signed [DSZ-1:0] in_q;
    logic [LSZ-1:0]        decim;
    logic signed [DSZ-1:0] out_i;
    logic signed [DSZ-1:0] out_q;
    logic                  out_valid;

    int     nchk = 0;
    int     nerr = 0;
    exp_t   sb[$];
    int     xi[MAXC];
    int     xq[MAXC];
    longint h[$];
    int     cyc = 0;
    int     cur = 0;
    int     d_cur = 1;
    int     next_strb = 0;
    int     nsup = 0;
    int     last_dec = 0;
    bit     mon_exp;
    exp_t   mon_e;

    tuner_cic_decim dut (
        .clk       (clk),
        .reset     (reset),
        .in_i      (in_i),
        .in_q      (in_q),
        .decim     (decim),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        nchk++;
        if (act != exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cur);
        end
    endtask

    // Impulse response of NST integrators followed by NST rate-R combs: boxcar of length R convolved NST times.
    function automatic void build_kernel(input int r);
        longint t[$];
        h.delete();
        h.push_back(1);
        repeat (NST) begin
            t.delete();
            for (int j = 0; j < h.size() + r - 1; j++) begin
                longint s;
                s = 0;
                for (int k = 0; k < r; k++)
                    if ((j - k >= 0) && (j - k < h.size()))
                        s += h[j - k];
                t.push_back(s);
            end
            h = t;
        end
    endfunction

    function automatic longint cic_sum(input int n, input bit qch);
        longint s;
        int     idx;
        s = 0;
        for (int j = 0; j < h.size(); j++) begin
            idx = n - NST - j;
            if (idx < 0)
                break;
            s += h[j] * longint'(qch ? xq[idx] : xi[idx]);
        end
        return s;
    endfunction

    function automatic int quant(input longint y, input int d);
        int     sh;
        longint v;
        sh = NST * d;
`ifdef TUNER_CIC_ROUND_EN
        v = (y + (longint'(1) <<< (sh - 1))) >>> sh;
        if (v > 32767)
            v = 32767;
        if (v < -32768)
            v = -32768;
`else
        v = y >>> sh;
`endif
        return int'(v);
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Called at posedge+1: apply one input cycle and update the reference schedule.
    task automatic step(input int vi, input int vq, input int dec);
        int   dn;
        exp_t e;
        dn = (dec == 0) ? 1 : ((dec > DMAX) ? DMAX : dec);
        in_i  = DSZ'(vi);
        in_q  = DSZ'(vq);
        decim = LSZ'(dec);
        xi[cyc] = vi;
        xq[cyc] = vq;
        cur = cyc;
        if (cyc == 0) begin
            d_cur = dn;
            build_kernel(1 << dn);
            next_strb = 1 << dn;
            nsup = 0;
        end else if (dn != d_cur) begin
            d_cur = dn;
            build_kernel(1 << dn);
            next_strb = cyc + (1 << dn);
            nsup = NST;
        end else if (cyc == next_strb) begin
            if (nsup > 0) begin
                nsup--;
            end else begin
                e.i   = quant(cic_sum(cyc, 1'b0), d_cur);
                e.q   = quant(cic_sum(cyc, 1'b1), d_cur);
                e.cyc = cyc + LAT;
                sb.push_back(e);
            end
            next_strb += 1 << d_cur;
        end
        cyc++;
        last_dec = dec;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seg(input int n, input int dec, input int mode, input int ci, input int cq);
        int vi;
        int vq;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       begin vi = ci;                      vq = cq;      end
                1:       begin vi = rnd16();                 vq = rnd16(); end
                default: begin vi = (k % 2 == 0) ? 1 : 2;    vq = rnd16(); end
            endcase
            step(vi, vq, dec);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        #1;
        chk("async_reset_out_valid", int'(out_valid), 0);
        chk("async_reset_out_i", int'(out_i), 0);
        chk("async_reset_out_q", int'(out_q), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            mon_exp = (sb.size() > 0) && (sb[0].cyc == cur);
            if (mon_exp || out_valid) begin
                chk("out_valid", int'(out_valid), int'(mon_exp));
                if (mon_exp) begin
                    mon_e = sb.pop_front();
                    if (out_valid) begin
                        chk("out_i", int'(out_i), mon_e.i);
                        chk("out_q", int'(out_q), mon_e.q);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        in_i  = '0;
        in_q  = '0;
        decim = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_i", int'(out_i), 0);
        chk("reset_out_q", int'(out_q), 0);
        reset = 1'b1;
        cyc = 0;

        run_seg(200, 3, 0, 1000, -1000);
        chk("dc_r8_out_i", int'(out_i), 1000);
        chk("dc_r8_out_q", int'(out_q), -1000);

        run_seg(256 * 7, 8, 0, 32767, -32768);
        chk("fullscale_out_i", int'(out_i), 32767);
        chk("fullscale_out_q", int'(out_q), -32768);

        run_seg(100, 0, 1, 0, 0);
        run_seg(256 * 7, 15, 1, 0, 0);

        run_seg(200, 2, 0, 500, -700);
        run_seg(200, 4, 0, 500, -700);
        chk("ratechange_out_i", int'(out_i), 500);
        chk("ratechange_out_q", int'(out_q), -700);

        run_seg(5, 4, 0, 500, -700);
        do_reset();
        run_seg(100, 3, 1, 0, 0);

        run_seg(60, 1, 2, 0, 0);
`ifdef TUNER_CIC_ROUND_EN
        chk("alternating_out_i", int'(out_i), 2);
`else
        chk("alternating_out_i", int'(out_i), 1);
`endif

        repeat (8) begin
            int n;
            int d;
            n = int'($urandom_range(700, 40));
            d = int'($urandom_range(15));
            run_seg(n, d, 1, 0, 0);
        end
        run_seg(LAT + 4, last_dec, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
